execute_stage_md: RTL
=====================

EXECUTE_STAGE_MD -- requirements
Module: execute_stage_md

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width; legal values are 32 and 64.
REQ-002 SHALL have parameter MUL_LATENCY, default 3: cycles from MUL-class accept to out_valid; legal range is 1 to 8.
REQ-003 SHALL have parameter DIV_ENABLE, default 1: 0 removes the divider, and DIV-class ops then return all-ones.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: operation presented.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts an op this cycle (combinational from state and out_ready).
REQ-008 SHALL have ports rs1, rs2, imm, pc, pc_4, input, XLEN bits each: operands.
REQ-009 SHALL have ports alu_rs1, alu_rs2, alu_op_code, branch_op, jal_op, jalr_op, input, with their params enum types: ALU, branch and jump controls.
REQ-010 SHALL have port md_en, input, 1 bit: op is M-extension; when set, it overrides the ALU, branch and jump controls.
REQ-011 SHALL have port md_op, input, 3 bits: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-012 SHALL have port flush, input, 1 bit: kill any in-flight or held op.
REQ-013 SHALL have port out_valid, output, 1 bit: result presented.
REQ-014 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-015 SHALL have port result, output, XLEN bits: ALU, link or M-extension result.
REQ-016 SHALL have port branch_taken, output, 1 bit: redirect required.
REQ-017 SHALL have port branch_target, output, XLEN bits: redirect address.

Function
REQ-018 SHALL implement states IDLE, MUL, DIV, DONE.
- An op is accepted when in_valid && in_ready.
- in_ready = IDLE || (DONE && out_ready).
REQ-019 SHALL register the result of a non-md op accepted in cycle N, with out_valid=1 in cycle N+1 (state DONE).
- result = ALU output; branch fields from branch compare.
- JAL: result = pc_4, target = pc+imm, taken = 1.
- JALR (when JAL is not set): result = pc_4, target = (rs1+imm) & ~1, taken = 1.
REQ-020 SHALL, for a MUL-class accept in cycle N, go to state MUL with a down-counter and assert out_valid in cycle N+MUL_LATENCY.
- MUL returns the low XLEN bits of the 2*XLEN product; MULH/MULHSU/MULHU return the high XLEN bits with signed*signed, signed*unsigned and unsigned*unsigned operands respectively.
REQ-021 SHALL implement DIV-class ops as a radix-2 restoring iterative divider: one quotient bit per cycle, out_valid in cycle N+XLEN+1, signs fixed up in the final cycle.
REQ-022 SHALL, on divide by zero, return quotient all-ones (DIV/DIVU) and remainder = rs1 (REM/REMU).
REQ-023 SHALL, on signed overflow (most-negative / -1), return quotient = rs1 and remainder = 0.
REQ-024 SHALL drive branch_taken=0 and branch_target=0 for md ops.
REQ-025 SHALL hold result, branch_taken and branch_target stable while out_valid && !out_ready.
REQ-026 SHALL, in DONE with out_ready=1, either load the next op if in_valid (back-to-back, no bubble) or go to IDLE with out_valid=0.
REQ-027 SHALL keep in_ready=0 while in MUL or DIV; in_valid there is ignored.
REQ-028 SHALL, on flush=1, go to IDLE and drop out_valid in the next cycle, discarding counters.
- flush takes priority over in_valid and over completion.
- in_ready SHALL be 0 in the flush cycle.
REQ-029 SHALL perform all address and ALU arithmetic modulo 2^XLEN, with carries discarded.

Reset
REQ-030 SHALL, while rst_n=0 at a clk edge, set state IDLE, out_valid 0, result 0, branch_taken 0, branch_target 0, and counters 0.
REQ-031 SHALL force in_ready=0 while rst_n=0, and drive in_ready=1 in the first cycle after release.
REQ-032 SHALL have reset abort a MUL or DIV in progress, with no result emitted afterwards.

Verification
REQ-033 SHALL cover a DIV mid-operation:
- DIV rs1=-7, rs2=2, accept cycle 0 -> out_valid at cycle 33, result=-3.
- Same op as REM -> result=-1.
REQ-034 SHALL cover divide-by-zero and overflow (XLEN=32):
- DIVU 5/0 -> 0xFFFFFFFF.
- REM 5/0 -> 5.
- DIV 0x80000000/-1 -> 0x80000000.
- REM 0x80000000/-1 -> 0.
REQ-035 SHALL cover back-to-back ALU ops: 3 ADD ops with out_ready=1 -> 3 consecutive out_valid cycles; out_ready=0 for 2 cycles -> result held and in_ready=0.
REQ-036 SHALL cover jumps:
- JAL pc=0x100, imm=0x20 -> result=0x104, target=0x120, taken=1.
- JALR rs1=0x205, imm=0 -> target=0x204.
REQ-037 SHALL cover MULH with MUL_LATENCY=3: rs1=0x80000000, rs2=2 -> 0xFFFFFFFF at cycle 3.
REQ-038 SHALL cover flush mid-DIV (cycle 10) and rst_n=0 mid-MUL -> no out_valid follows, and in_ready=1 one cycle later.

Source files
------------

// File: rtl/execute_stage_md.sv
// Execute stage with single-cycle ALU/branch/jump path, fixed-latency multiplier
// and radix-2 restoring divider, behind a valid/ready handshake.
package execute_stage_md_pkg;
    typedef enum logic {RS1_REG, RS1_PC} alu_rs1_e;
    typedef enum logic {RS2_REG, RS2_IMM} alu_rs2_e;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI
    } alu_op_e;
    typedef enum logic [2:0] {BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU} branch_op_e;
    typedef enum logic {JAL_NO, JAL_YES} jal_op_e;
    typedef enum logic {JALR_NO, JALR_YES} jalr_op_e;
endpackage

module execute_stage_md
    import execute_stage_md_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 3,
    parameter int DIV_ENABLE  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_4,
    input  alu_rs1_e        alu_rs1,
    input  alu_rs2_e        alu_rs2,
    input  alu_op_e         alu_op_code,
    input  branch_op_e      branch_op,
    input  jal_op_e         jal_op,
    input  jalr_op_e        jalr_op,
    input  logic            md_en,
    input  logic [2:0]      md_op,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target
);
    localparam int SHW = $clog2(XLEN);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   res_q, res_d, target_q, target_d;
    logic              taken_q, taken_d;
    logic [6:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic              qneg_q, qneg_d, rneg_q, rneg_d, isrem_q, isrem_d;

    logic [XLEN-1:0]   op_a, op_b, alu_res, jalr_sum;
    logic [SHW-1:0]    shamt;
    logic              br_cond, accept, a_neg, b_neg;
    logic [2*XLEN-1:0] mul_a, mul_b, prod;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN:0]     div_shift, div_trial;
    logic              div_bit;
    logic [XLEN-1:0]   quo_n, rem_n, div_res;

    // ALU and branch compare
    assign op_a     = (alu_rs1 == RS1_PC) ? pc : rs1;
    assign op_b     = (alu_rs2 == RS2_IMM) ? imm : rs2;
    assign shamt    = op_b[SHW-1:0];
    assign jalr_sum = rs1 + imm;

    always_comb begin
        alu_res = '0;
        case (alu_op_code)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
            ALU_SLTU: alu_res = XLEN'(op_a < op_b);
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SRA:  alu_res = XLEN'($signed(op_a) >>> shamt);
            ALU_OR:   alu_res = op_a | op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_LUI:  alu_res = op_b;
            default:  alu_res = '0;
        endcase
        br_cond = 1'b0;
        case (branch_op)
            BR_EQ:   br_cond = (rs1 == rs2);
            BR_NE:   br_cond = (rs1 != rs2);
            BR_LT:   br_cond = ($signed(rs1) < $signed(rs2));
            BR_GE:   br_cond = ($signed(rs1) >= $signed(rs2));
            BR_LTU:  br_cond = (rs1 < rs2);
            BR_GEU:  br_cond = (rs1 >= rs2);
            default: br_cond = 1'b0;
        endcase
    end

    // Operands widened by the op's signedness so one 2*XLEN product serves all four ops
    assign mul_a   = {{XLEN{rs1[XLEN-1] & (md_op[1:0] != 2'd3)}}, rs1};
    assign mul_b   = {{XLEN{rs2[XLEN-1] & ~md_op[1]}}, rs2};
    assign prod    = mul_a * mul_b;
    assign mul_res = (md_op[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    // One restoring step: divisor of zero always "fits", giving all-ones quotient and rem = |rs1|
    assign a_neg     = ~md_op[0] & rs1[XLEN-1];
    assign b_neg     = ~md_op[0] & rs2[XLEN-1];
    assign div_shift = {rem_q, quo_q[XLEN-1]};
    assign div_trial = div_shift - {1'b0, dvs_q};
    assign div_bit   = ~div_trial[XLEN];
    assign rem_n     = div_bit ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
    assign quo_n     = {quo_q[XLEN-2:0], div_bit};
    assign div_res   = isrem_q ? (rneg_q ? -rem_n : rem_n) : (qneg_q ? -quo_n : quo_n);

    always_comb begin
        in_ready  = 1'b0;
        if (rst_n && !flush)
            in_ready = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
        out_valid = (state_q == S_DONE);
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        taken_d  = taken_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        isrem_d  = isrem_q;
        case (state_q)
            S_DONE: if (out_ready) state_d = S_IDLE;
            S_MUL: begin
                cnt_d = cnt_q - 7'd1;
                if (cnt_q == 7'd1) state_d = S_DONE;
            end
            S_DIV: begin
                cnt_d = cnt_q - 7'd1;
                quo_d = quo_n;
                rem_d = rem_n;
                if (cnt_q == 7'd1) begin
                    state_d = S_DONE;
                    res_d   = div_res;
                end
            end
            default: ;
        endcase
        if (accept) begin
            state_d  = S_DONE;
            taken_d  = 1'b0;
            target_d = '0;
            if (!md_en) begin
                if (jal_op == JAL_YES) begin
                    res_d    = pc_4;
                    target_d = pc + imm;
                    taken_d  = 1'b1;
                end else if (jalr_op == JALR_YES) begin
                    res_d    = pc_4;
                    target_d = {jalr_sum[XLEN-1:1], 1'b0};
                    taken_d  = 1'b1;
                end else begin
                    res_d    = alu_res;
                    target_d = pc + imm;
                    taken_d  = br_cond;
                end
            end else if (!md_op[2]) begin
                res_d = mul_res;
                if (MUL_LATENCY > 1) begin
                    state_d = S_MUL;
                    cnt_d   = 7'(MUL_LATENCY - 1);
                end
            end else if (DIV_ENABLE == 0) begin
                res_d = '1;
            end else begin
                state_d = S_DIV;
                cnt_d   = 7'(XLEN);
                quo_d   = a_neg ? -rs1 : rs1;
                dvs_d   = b_neg ? -rs2 : rs2;
                rem_d   = '0;
                qneg_d  = (a_neg ^ b_neg) && (rs2 != '0);
                rneg_d  = a_neg;
                isrem_d = md_op[1];
            end
        end
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            res_q    <= '0;
            taken_q  <= 1'b0;
            target_q <= '0;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            isrem_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            taken_q  <= taken_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            isrem_q  <= isrem_d;
        end
    end

    assign result        = res_q;
    assign branch_taken  = taken_q;
    assign branch_target = target_q;
endmodule
